// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared definitions for the pipeline stage controller:
//                sequencer state encoding and default geometry.
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_pkg;

    localparam int unsigned c_DEF_STAGES = 4;
    localparam int unsigned c_DEF_TAG_W  = 4;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // pipe empty
        ST_BUSY  = 2'd1,   // items in flight, accepting
        ST_DRAIN = 2'd2    // not accepting, waiting for the pipe to empty
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pipe_stage_slot.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_slot
//  Description : One pipeline slot: valid bit, tag register and the load
//                enable for the matching datapath register bank.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk        in   1      rising-edge clock
//    rstn       in   1      asynchronous active-low reset
//    i_req      in   1      an item is offered to this slot
//    i_rdy_out  in   1      downstream slot can take this slot's item
//    i_flush    in   1      discard contents
//    i_tag      in   TAG_W  tag of the offered item
//    o_rdy      out  1      this slot can take an item this cycle
//    o_en       out  1      load enable (item enters this slot)
//    o_vld      out  1      slot holds a valid item
//    o_tag      out  TAG_W  tag of the held item
// ============================================================================
module pipe_stage_slot #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_req,
    input  logic             i_rdy_out,
    input  logic             i_flush,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_rdy,
    output logic             o_en,
    output logic             o_vld,
    output logic [TAG_W-1:0] o_tag
);

    logic             r_vld;
    logic [TAG_W-1:0] r_tag;
    logic             w_rdy;
    logic             w_en;

    // A slot can take a new item when it is empty or its item moves on,
    // which is what lets bubbles collapse.
    assign w_rdy = ~r_vld | i_rdy_out;
    assign w_en  = i_req & w_rdy & ~i_flush;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vld <= 1'b0;
            r_tag <= '0;
        end else begin
            if (i_flush) begin
                r_vld <= 1'b0;
            end else begin
                r_vld <= w_en | (r_vld & ~i_rdy_out);
            end
            if (w_en) begin
                r_tag <= i_tag;
            end
        end
    end

    assign o_rdy = w_rdy;
    assign o_en  = w_en;
    assign o_vld = r_vld;
    assign o_tag = r_tag;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_ctrl
//  Description : Valid/stall sequencer for a STAGES-deep register pipeline.
//                Produces per-stage load enables, tracks valid bits and tags,
//                applies valid/ready backpressure, supports drain and flush.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk         in   1       rising-edge clock
//    rstn        in   1       asynchronous active-low reset
//    in_valid    in   1       upstream item present
//    in_ready    out  1       item accepted this cycle
//    in_tag      in   TAG_W   tag of upstream item
//    out_valid   out  1       last stage holds a valid item
//    out_ready   in   1       consumer accepts item
//    out_tag     out  TAG_W   tag of the last-stage item
//    stage_en    out  STAGES  datapath load enables (bit 0 = first stage)
//    stage_vld   out  STAGES  per-stage valid bits
//    flush       in   1       discard all in-flight items
//    drain_req   in   1       stop accepting and empty the pipe
//    drain_done  out  1       one-cycle pulse when a drain completes
//    occupancy   out  OCC_W   number of valid stages
//    busy        out  1       occupancy != 0
// ============================================================================
module pipe_stage_ctrl
    import pipe_pkg::*;
#(
    parameter int STAGES = c_DEF_STAGES,
    parameter int TAG_W  = c_DEF_TAG_W,
    parameter int OCC_W  = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TAG_W-1:0]  out_tag,
    output logic [STAGES-1:0] stage_en,
    output logic [STAGES-1:0] stage_vld,
    input  logic              flush,
    input  logic              drain_req,
    output logic              drain_done,
    output logic [OCC_W-1:0]  occupancy,
    output logic              busy
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [OCC_W-1:0]    r_occ;
    logic [OCC_W-1:0]    w_occ_nxt;
    logic                r_done;
    logic                w_done_nxt;

    logic [STAGES:0]     w_rdy;
    logic [STAGES-1:0]   w_req;
    logic [STAGES-1:0]   w_en;
    logic [STAGES-1:0]   w_vld;
    logic [TAG_W-1:0]    w_tag    [STAGES];
    logic [TAG_W-1:0]    w_tag_in [STAGES];

    logic                w_accept_ok;
    logic                w_in_hs;
    logic                w_out_hs;

    // A drain request blocks acceptance in the same cycle it is raised.
    assign w_accept_ok = (r_state != ST_DRAIN) & ~drain_req & ~flush;
    assign w_rdy[STAGES] = out_ready;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_slot
            if (k == 0) begin : g_head
                assign w_req[k]    = in_valid & w_accept_ok;
                assign w_tag_in[k] = in_tag;
            end else begin : g_body
                assign w_req[k]    = w_vld[k-1];
                assign w_tag_in[k] = w_tag[k-1];
            end

            pipe_stage_slot #(
                .TAG_W (TAG_W)
            ) u_slot (
                .clk       (clk),
                .rstn      (rstn),
                .i_req     (w_req[k]),
                .i_rdy_out (w_rdy[k+1]),
                .i_flush   (flush),
                .i_tag     (w_tag_in[k]),
                .o_rdy     (w_rdy[k]),
                .o_en      (w_en[k]),
                .o_vld     (w_vld[k]),
                .o_tag     (w_tag[k])
            );
        end
    endgenerate

    assign in_ready  = w_rdy[0] & w_accept_ok;
    assign out_valid = w_vld[STAGES-1] & ~flush;
    assign out_tag   = w_tag[STAGES-1];
    assign stage_en  = w_en;
    assign stage_vld = w_vld;

    assign w_in_hs  = w_en[0];
    assign w_out_hs = out_valid & out_ready;

    // Occupancy tracks handshakes rather than popcounting the valid bits.
    always_comb begin
        w_occ_nxt = r_occ;
        if (flush) begin
            w_occ_nxt = '0;
        end else if (w_in_hs && !w_out_hs) begin
            w_occ_nxt = r_occ + OCC_W'(1);
        end else if (!w_in_hs && w_out_hs) begin
            w_occ_nxt = r_occ - OCC_W'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        if (flush) begin
            // Flush aborts any drain silently.
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (drain_req) begin
                        w_state_nxt = ST_DRAIN;
                    end else if (w_in_hs) begin
                        w_state_nxt = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (drain_req) begin
                        w_state_nxt = ST_DRAIN;
                    end else if (w_occ_nxt == '0) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (w_occ_nxt == '0) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_occ   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_occ   <= w_occ_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign drain_done = r_done;
    assign occupancy  = r_occ;
    assign busy       = (r_occ != '0);

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_ctrl
//  Description : Self-checking bench for pipe_stage_ctrl (STAGES=4, TAG_W=4).
//                Reference model: an ordered list of in-flight items, each
//                with a pipeline position; items step forward when the slot
//                ahead is free after the older item has moved.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_stage_ctrl;

    localparam int S  = 4;
    localparam int TW = 4;
    localparam int OW = 3;

    logic          clk       = 1'b0;
    logic          rstn      = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [TW-1:0] in_tag    = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [TW-1:0] out_tag;
    logic [S-1:0]  stage_en;
    logic [S-1:0]  stage_vld;
    logic          flush     = 1'b0;
    logic          drain_req = 1'b0;
    logic          drain_done;
    logic [OW-1:0] occupancy;
    logic          busy;

    always #5 clk = ~clk;

    pipe_stage_ctrl #(
        .STAGES (S),
        .TAG_W  (TW),
        .OCC_W  (OW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_tag    (out_tag),
        .stage_en   (stage_en),
        .stage_vld  (stage_vld),
        .flush      (flush),
        .drain_req  (drain_req),
        .drain_done (drain_done),
        .occupancy  (occupancy),
        .busy       (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- reference model ----------------
    int      q_tag[$];     // oldest first
    int      q_pos[$];     // stage index of each item
    bit      m_drain = 1'b0;
    bit      m_done  = 1'b0;
    int      e_new[$];
    bit      e_accept;
    logic          e_in_ready;
    logic          e_out_valid;
    logic [TW-1:0] e_out_tag;
    logic [S-1:0]  e_en;
    logic [S-1:0]  e_vld;
    int            e_occ;
    logic          e_done;

    function automatic void model_reset();
        q_tag.delete();
        q_pos.delete();
        m_drain = 1'b0;
        m_done  = 1'b0;
    endfunction

    function automatic void model_eval();
        int lim;
        int np;
        e_new.delete();
        e_en  = '0;
        e_vld = '0;
        lim   = S - 1;
        foreach (q_pos[i]) begin
            e_vld[q_pos[i]] = 1'b1;
            if (q_pos[i] == S - 1) begin
                if (out_ready) begin
                    np = S;
                end else begin
                    np  = S - 1;
                    lim = S - 2;
                end
            end else begin
                np  = (q_pos[i] + 1 <= lim) ? q_pos[i] + 1 : q_pos[i];
                lim = np - 1;
                if (np != q_pos[i]) e_en[np] = 1'b1;
            end
            e_new.push_back(np);
        end
        e_in_ready = (lim >= 0) && !m_drain && !drain_req && !flush;
        e_accept   = e_in_ready && in_valid;
        if (e_accept) e_en[0] = 1'b1;
        if (flush) e_en = '0;
        e_out_valid = (q_pos.size() > 0) && (q_pos[0] == S - 1) && !flush;
        e_out_tag   = (q_tag.size() > 0) ? TW'(q_tag[0]) : '0;
        e_occ       = q_pos.size();
        e_done      = m_done;
    endfunction

    function automatic void model_commit();
        int nt[$];
        int np[$];
        if (flush) begin
            model_reset();
        end else begin
            foreach (e_new[i]) begin
                if (e_new[i] < S) begin
                    nt.push_back(q_tag[i]);
                    np.push_back(e_new[i]);
                end
            end
            if (e_accept) begin
                nt.push_back(int'(in_tag));
                np.push_back(0);
            end
            q_tag  = nt;
            q_pos  = np;
            m_done = m_drain && (q_pos.size() == 0);
            if (m_done) m_drain = 1'b0;
            else if (!m_drain && drain_req) m_drain = 1'b1;
        end
    endfunction

    // Drive inputs mid-low-phase and compute this cycle's expectations.
    task automatic drive(input logic iv, input logic [TW-1:0] tg, input logic ordy,
                         input logic drq, input logic fl);
        @(negedge clk);
        in_valid  = iv;
        in_tag    = tg;
        out_ready = ordy;
        drain_req = drq;
        flush     = fl;
        #1;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
        n_checks++; if ({out_valid, busy, drain_done} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {out_valid, busy, drain_done}); else n_pass++;
        n_checks++; if (occupancy !== 3'd0) $display("FAIL reset_occ: got %0d want 0", occupancy); else n_pass++;
        n_checks++; if (stage_vld !== 4'b0000) $display("FAIL reset_vld: got %b want 0000", stage_vld); else n_pass++;
        n_checks++; if (out_tag !== 4'h0) $display("FAIL reset_tag: got %h want 0", out_tag); else n_pass++;
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
    endtask

    task automatic test_stream();
        int acc_cyc   = -1;
        int first_out = -1;
        int peak      = 0;
        logic [TW-1:0] got[$];
        for (int c = 0; c < 20; c++) begin
            drive(c < 8, TW'(c), 1'b1, 1'b0, 1'b0);
            if (in_valid && in_ready && acc_cyc < 0) acc_cyc = c;
            if (out_valid) begin
                if (first_out < 0) first_out = c;
                got.push_back(out_tag);
            end
            if (int'(occupancy) > peak) peak = int'(occupancy);
            n_checks++; if (in_ready !== e_in_ready) $display("FAIL stream_in_ready c%0d: got %b want %b", c, in_ready, e_in_ready); else n_pass++;
            tick();
        end
        // Accepted at edge N -> visible after edge N+S-1, i.e. S cycles after the accept cycle.
        n_checks++; if (first_out - acc_cyc !== S) $display("FAIL stream_latency: got %0d want %0d", first_out - acc_cyc, S); else n_pass++;
        n_checks++; if (got.size() !== 8) $display("FAIL stream_count: got %0d want 8", got.size()); else n_pass++;
        for (int i = 0; i < got.size(); i++) begin
            n_checks++; if (got[i] !== TW'(i)) $display("FAIL stream_order %0d: got %h want %h", i, got[i], TW'(i)); else n_pass++;
        end
        n_checks++; if (peak !== 4) $display("FAIL stream_peak_occ: got %0d want 4", peak); else n_pass++;
    endtask

    task automatic test_stall();
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, TW'(8 + c), 1'b0, 1'b0, 1'b0);
            tick();
        end
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 4'hF, 1'b0, 1'b0, 1'b0);
            n_checks++; if (occupancy !== 3'd4) $display("FAIL stall_occ c%0d: got %0d want 4", c, occupancy); else n_pass++;
            n_checks++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready c%0d: got %b want 0", c, in_ready); else n_pass++;
            n_checks++; if (stage_en !== 4'b0000) $display("FAIL stall_en c%0d: got %b want 0000", c, stage_en); else n_pass++;
            tick();
        end
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
            n_checks++;
            if (out_valid !== 1'b1 || out_tag !== TW'(8 + c))
                $display("FAIL stall_release c%0d: got v=%b tag=%h want v=1 tag=%h", c, out_valid, out_tag, TW'(8 + c));
            else n_pass++;
            tick();
        end
        drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (occupancy !== 3'd0 || out_valid !== 1'b0) $display("FAIL stall_empty: got occ=%0d v=%b want occ=0 v=0", occupancy, out_valid); else n_pass++;
        tick();
    endtask

    task automatic test_bubble();
        drive(1'b1, 4'h1, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b1, 4'h2, 1'b0, 1'b0, 1'b0); tick();
        repeat (4) begin
            drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0); tick();
        end
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (stage_vld !== 4'b1100) $display("FAIL bubble_vld: got %b want 1100", stage_vld); else n_pass++;
        n_checks++; if (occupancy !== 3'd2) $display("FAIL bubble_occ: got %0d want 2", occupancy); else n_pass++;
        n_checks++; if (out_valid !== 1'b1 || out_tag !== 4'h1) $display("FAIL bubble_head: got v=%b tag=%h want v=1 tag=1", out_valid, out_tag); else n_pass++;
        tick();
        drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (out_valid !== 1'b1 || out_tag !== 4'h1) $display("FAIL bubble_out1: got v=%b tag=%h want v=1 tag=1", out_valid, out_tag); else n_pass++;
        tick();
        drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (out_valid !== 1'b1 || out_tag !== 4'h2) $display("FAIL bubble_out2: got v=%b tag=%h want v=1 tag=2", out_valid, out_tag); else n_pass++;
        tick();
    endtask

    task automatic test_drain();
        int lows  = 0;
        int dones = 0;
        bit seen  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, TW'(3 + c), 1'b1, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 4'hA, 1'b1, 1'b1, 1'b0);
        n_checks++; if (in_ready !== 1'b0) $display("FAIL drain_req_cycle_in_ready: got %b want 0", in_ready); else n_pass++;
        tick();
        for (int c = 0; c < 12; c++) begin
            drive(!seen, 4'hB, 1'b1, 1'b0, 1'b0);
            if (drain_done === 1'b1) dones++;
            if (!seen) begin
                if (drain_done === 1'b1) begin
                    seen = 1'b1;
                    n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL drain_idle: got rdy=%b busy=%b want rdy=1 busy=0", in_ready, busy); else n_pass++;
                end else if (in_ready === 1'b0) begin
                    lows++;
                end
            end
            n_checks++; if (drain_done !== e_done) $display("FAIL drain_done c%0d: got %b want %b", c, drain_done, e_done); else n_pass++;
            tick();
        end
        n_checks++; if (lows !== 3) $display("FAIL drain_block_cycles: got %0d want 3", lows); else n_pass++;
        n_checks++; if (dones !== 1) $display("FAIL drain_pulses: got %0d want 1", dones); else n_pass++;
        drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (occupancy !== 3'd0) $display("FAIL drain_final_occ: got %0d want 0", occupancy); else n_pass++;
        tick();
    endtask

    task automatic test_flush();
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, TW'(12 + c), 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 4'h5, 1'b1, 1'b0, 1'b1);
        n_checks++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready: got %b want 0", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (stage_en !== 4'b0000) $display("FAIL flush_en: got %b want 0000", stage_en); else n_pass++;
        tick();
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
            if (c == 0) begin
                n_checks++; if (stage_vld !== 4'b0000) $display("FAIL flush_vld: got %b want 0000", stage_vld); else n_pass++;
                n_checks++; if (occupancy !== 3'd0) $display("FAIL flush_occ: got %0d want 0", occupancy); else n_pass++;
            end
            n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_leak c%0d: got v=%b tag=%h want v=0", c, out_valid, out_tag); else n_pass++;
            tick();
        end
    endtask

    task automatic test_async_reset();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, TW'(c), 1'b1, 1'b0, 1'b0);
            tick();
        end
        #2;
        rstn      = 1'b0;
        #1;
        n_checks++; if (stage_vld !== 4'b0000) $display("FAIL areset_vld: got %b want 0000", stage_vld); else n_pass++;
        n_checks++; if (occupancy !== 3'd0) $display("FAIL areset_occ: got %0d want 0", occupancy); else n_pass++;
        n_checks++; if ({out_valid, busy, drain_done} !== 3'b000) $display("FAIL areset_flags: got %b want 000", {out_valid, busy, drain_done}); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL areset_in_ready: got %b want 1", in_ready); else n_pass++;
        in_valid  = 1'b0;
        drain_req = 1'b0;
        flush     = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 99) < 70, TW'($urandom), $urandom_range(0, 99) < 70,
                  $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 3);
            n_checks++; if (in_ready !== e_in_ready) $display("FAIL rnd_in_ready c%0d: got %b want %b", c, in_ready, e_in_ready); else n_pass++;
            n_checks++; if (out_valid !== e_out_valid) $display("FAIL rnd_out_valid c%0d: got %b want %b", c, out_valid, e_out_valid); else n_pass++;
            if (e_out_valid) begin
                n_checks++; if (out_tag !== e_out_tag) $display("FAIL rnd_out_tag c%0d: got %h want %h", c, out_tag, e_out_tag); else n_pass++;
            end
            n_checks++; if (stage_en !== e_en) $display("FAIL rnd_stage_en c%0d: got %b want %b", c, stage_en, e_en); else n_pass++;
            n_checks++; if (stage_vld !== e_vld) $display("FAIL rnd_stage_vld c%0d: got %b want %b", c, stage_vld, e_vld); else n_pass++;
            n_checks++; if (occupancy !== OW'(e_occ)) $display("FAIL rnd_occ c%0d: got %0d want %0d", c, occupancy, e_occ); else n_pass++;
            n_checks++; if (busy !== (e_occ != 0)) $display("FAIL rnd_busy c%0d: got %b want %b", c, busy, e_occ != 0); else n_pass++;
            n_checks++; if (drain_done !== e_done) $display("FAIL rnd_drain_done c%0d: got %b want %b", c, drain_done, e_done); else n_pass++;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_bubble();
        test_drain();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
